sprite_addr_calc: RTL and testbench

- Per-sprite address generator for the sprite display path.
- Takes a pattern descriptor (ROM base and geometry) and a sprite state word (visibility, flip, position, scroll). For the current VGA beam position (hcount, vcount), it produces the pixel index into the sprite pattern ROM and a hit flag.
- One instance per sprite slot. The parent display block uses the address to fetch a 2-bit palette index and uses valid to pick the front-most opaque sprite.

---
 rtl/sprite_pkg.sv | 45 ++++
 rtl/sprite_addr_calc.sv | 86 ++++++++
 tb/tb_sprite_addr_calc.sv | 135 +++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite display path.
// Holds field offsets and packed views of the pattern descriptor and the
// sprite state word, plus the default address and coordinate widths.
package sprite_pkg;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned COORD_W = 10;

    // pattern_info field offsets
    localparam int unsigned PI_BASE_MSB   = 79;
    localparam int unsigned PI_BASE_LSB   = 64;
    localparam int unsigned PI_WIDTH_MSB  = 63;
    localparam int unsigned PI_WIDTH_LSB  = 48;
    localparam int unsigned PI_HEIGHT_MSB = 47;
    localparam int unsigned PI_HEIGHT_LSB = 32;
    localparam int unsigned PI_STRIDE_MSB = 31;
    localparam int unsigned PI_STRIDE_LSB = 16;

    // sprite_info field offsets
    localparam int unsigned SI_VIS       = 31;
    localparam int unsigned SI_FLIP      = 30;
    localparam int unsigned SI_X_MSB     = 29;
    localparam int unsigned SI_X_LSB     = 20;
    localparam int unsigned SI_Y_MSB     = 19;
    localparam int unsigned SI_Y_LSB     = 10;
    localparam int unsigned SI_SHIFT_MSB = 9;
    localparam int unsigned SI_SHIFT_LSB = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] width;
        logic [ADDR_W-1:0] height;
        logic [ADDR_W-1:0] stride;
        logic [15:0]       rsvd;
    } pattern_info_t;

    typedef struct packed {
        logic               visible;
        logic               flip;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] shift;
    } sprite_info_t;

endpackage

// File: rtl/sprite_addr_calc.sv
// Per-sprite pattern ROM address generator.
// For the current beam position, computes whether the beam lies inside this
// sprite and, if so, the pixel index into the pattern ROM. One cycle latency.
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   pattern_info {base, width, height, stride, reserved}
//   sprite_info  {visible, flip, x, y, shift}
//   hcount       beam column
//   vcount       beam row
//   addr_output  registered pattern pixel index (0 on miss)
//   valid        registered hit flag
module sprite_addr_calc #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned COORD_W = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4*ADDR_W+15:0] pattern_info,
    input  logic [31:0]          sprite_info,
    input  logic [COORD_W-1:0]   hcount,
    input  logic [COORD_W-1:0]   vcount,
    output logic [ADDR_W-1:0]    addr_output,
    output logic                 valid
);
    import sprite_pkg::*;

    // Two extra bits: one for sign, one so hcount - sx (up to 2*1023) fits.
    localparam int unsigned SW = COORD_W + 2;

    pattern_info_t pi;
    sprite_info_t  si;

    logic signed [SW-1:0] sx;
    logic signed [SW-1:0] dx;
    logic signed [SW-1:0] dy;
    logic [ADDR_W-1:0]    dx_u;
    logic [ADDR_W-1:0]    dy_u;
    logic                 dx_in;
    logic                 dy_in;
    logic                 hit;
    logic [ADDR_W-1:0]    col;
    logic [ADDR_W-1:0]    addr_d;
    logic [ADDR_W-1:0]    addr_q;
    logic                 valid_q;
    logic                 unused_rsvd;

    assign pi = pattern_info_t'(pattern_info);
    assign si = sprite_info_t'(sprite_info);
    assign unused_rsvd = ^pi.rsvd;

    always_comb begin
        sx = $signed({2'b00, si.x}) - $signed({2'b00, si.shift});
        dx = $signed({2'b00, hcount}) - sx;
        dy = $signed({2'b00, vcount}) - $signed({2'b00, si.y});

        dx_u = ADDR_W'($unsigned(dx));
        dy_u = ADDR_W'($unsigned(dy));

        // Negative offsets fail on the sign bit; zero width/height never passes '<'.
        dx_in = !dx[SW-1] && (dx_u < pi.width);
        dy_in = !dy[SW-1] && (dy_u < pi.height);
        hit   = si.visible && dx_in && dy_in;

        col = si.flip ? (pi.width - ADDR_W'(1) - dx_u) : dx_u;

        addr_d = '0;
        if (hit) begin
            addr_d = pi.base + dy_u * pi.stride + col;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            valid_q <= hit;
        end
    end

    assign addr_output = addr_q;
    assign valid       = valid_q;

endmodule

// File: tb/tb_sprite_addr_calc.sv
// Directed self-checking bench for sprite_addr_calc.
module tb_sprite_addr_calc;

    logic        clk;
    logic        reset;
    logic [79:0] pattern_info;
    logic [31:0] sprite_info;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic [15:0] addr_output;
    logic        valid;

    int checks;
    int failures;

    sprite_addr_calc dut (
        .clk          (clk),
        .reset        (reset),
        .pattern_info (pattern_info),
        .sprite_info  (sprite_info),
        .hcount       (hcount),
        .vcount       (vcount),
        .addr_output  (addr_output),
        .valid        (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [79:0] mk_pi(input logic [15:0] base, input logic [15:0] w,
                                          input logic [15:0] h, input logic [15:0] stride);
        return {base, w, h, stride, 16'h0000};
    endfunction

    function automatic logic [31:0] mk_si(input logic vis, input logic flip, input logic [9:0] x,
                                          input logic [9:0] y, input logic [9:0] shift);
        return {vis, flip, x, y, shift};
    endfunction

    task automatic check(input string tag, input logic exp_valid, input logic [15:0] exp_addr);
        checks++;
        assert ({valid, addr_output} === {exp_valid, exp_addr})
        else begin
            failures++;
            $error("FAIL %s: got valid=%0b addr=%0d, want valid=%0b addr=%0d",
                   tag, valid, addr_output, exp_valid, exp_addr);
        end
    endtask

    // Apply inputs away from the edge, clock once, sample just after the edge.
    task automatic step(input logic [79:0] p, input logic [31:0] s, input logic [9:0] h,
                        input logic [9:0] v, input string tag, input logic exp_valid,
                        input logic [15:0] exp_addr);
        @(negedge clk);
        pattern_info = p;
        sprite_info  = s;
        hcount       = h;
        vcount       = v;
        @(posedge clk);
        #1;
        check(tag, exp_valid, exp_addr);
    endtask

    initial begin
        logic [79:0] p16;
        logic [79:0] p256;
        checks   = 0;
        failures = 0;
        p16  = mk_pi(16'd0, 16'd16, 16'd16, 16'd16);
        p256 = mk_pi(16'd256, 16'd16, 16'd16, 16'd16);

        // Reset held with an in-range visible sprite.
        reset        = 1'b0;
        pattern_info = p16;
        sprite_info  = mk_si(1'b1, 1'b0, 10'd100, 10'd50, 10'd0);
        hcount       = 10'd103;
        vcount       = 10'd52;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", 1'b0, 16'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release", 1'b1, 16'd35);

        // Asynchronous clear mid-frame, between edges.
        #2;
        reset = 1'b0;
        #1;
        check("async_clear", 1'b0, 16'd0);
        @(negedge clk);
        reset = 1'b1;

        // Basic hit and right edge.
        step(p16, mk_si(1, 0, 100, 50, 0), 103, 52, "basic_hit", 1'b1, 16'd35);
        step(p16, mk_si(1, 0, 100, 50, 0), 115, 52, "col_last", 1'b1, 16'd47);
        step(p16, mk_si(1, 0, 100, 50, 0), 116, 52, "col_past", 1'b0, 16'd0);
        step(p16, mk_si(1, 0, 100, 50, 0), 99, 52, "col_before", 1'b0, 16'd0);

        // Flip with second pattern.
        step(p256, mk_si(1, 1, 100, 50, 0), 100, 50, "flip_left", 1'b1, 16'd271);
        step(p256, mk_si(1, 1, 100, 50, 0), 115, 50, "flip_right", 1'b1, 16'd256);
        step(p256, mk_si(1, 1, 100, 50, 0), 103, 52, "flip_mid", 1'b1, 16'd300);

        // Scroll: sx = 10 - 15 = -5, width 17.
        step(mk_pi(0, 17, 16, 16), mk_si(1, 0, 10, 50, 15), 0, 50, "scroll_first", 1'b1, 16'd5);
        step(mk_pi(0, 17, 16, 16), mk_si(1, 0, 10, 50, 15), 11, 50, "scroll_last", 1'b1, 16'd16);
        step(mk_pi(0, 17, 16, 16), mk_si(1, 0, 10, 50, 15), 12, 50, "scroll_past", 1'b0, 16'd0);

        // Invisible and zero-size.
        step(p16, mk_si(0, 0, 100, 50, 0), 103, 52, "invisible", 1'b0, 16'd0);
        step(mk_pi(0, 0, 16, 16), mk_si(1, 0, 100, 50, 0), 100, 52, "zero_w", 1'b0, 16'd0);
        step(mk_pi(0, 16, 0, 16), mk_si(1, 0, 100, 50, 0), 100, 50, "zero_h", 1'b0, 16'd0);

        // Row edges.
        step(p16, mk_si(1, 0, 100, 50, 0), 103, 49, "row_before", 1'b0, 16'd0);
        step(p16, mk_si(1, 0, 100, 50, 0), 103, 65, "row_last", 1'b1, 16'd243);
        step(p16, mk_si(1, 0, 100, 50, 0), 103, 66, "row_past", 1'b0, 16'd0);

        // Extreme coordinates must not wrap into hits.
        step(p16, mk_si(1, 0, 1023, 50, 0), 0, 50, "x_max", 1'b0, 16'd0);
        step(p16, mk_si(1, 0, 0, 1023, 0), 0, 0, "y_max", 1'b0, 16'd0);
        step(p16, mk_si(1, 0, 0, 50, 1023), 0, 50, "shift_max", 1'b0, 16'd0);
        step(p16, mk_si(1, 0, 1023, 0, 0), 1023, 0, "x_max_hit", 1'b1, 16'd0);

        // Address wraps modulo 2^16: 0xFFF0 + 2*16 + 0 = 0x0010.
        step(mk_pi(16'hFFF0, 16, 16, 16), mk_si(1, 0, 100, 50, 0), 100, 52, "addr_wrap",
             1'b1, 16'h0010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
